ctrl_unit: RTL

//   Control FSM that fetches 8-bit instructions, decodes them and drives the
//   ALU one-hot alu_mode, operand selects and datapath write enables.

---
 rtl/ctrl_unit_if.sv | 27 ++
 rtl/ctrl_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ctrl_unit_if.sv
// ctrl_unit_if: instruction-fetch bus between ctrl_unit and instruction memory.
//   imem_req   fetch request (master -> slave)
//   imem_addr  fetch address, BIT_COUNT wide (master -> slave)
//   imem_rdata 8-bit instruction word (slave -> master)
//   imem_valid imem_rdata valid this cycle (slave -> master)
// Also provides the one-hot ALU mode bit positions shared with the datapath.

`ifndef ALU_MODE_COUNT
`define ALU_MODE_ADD      0
`define ALU_MODE_SHIFT    1
`define ALU_MODE_NOT      2
`define ALU_MODE_AND      3
`define ALU_MODE_OR       4
`define ALU_MODE_BYPASS_A 5
`define ALU_MODE_BYPASS_B 6
`define ALU_MODE_COUNT    7
`endif

interface ctrl_unit_if #(parameter int BIT_COUNT = 8);
    logic                 imem_req;
    logic [BIT_COUNT-1:0] imem_addr;
    logic [7:0]           imem_rdata;
    logic                 imem_valid;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/ctrl_unit.sv
// ctrl_unit: FETCH/EXEC/HALT control FSM. Fetches 8-bit instructions over the
// imem bus, decodes them for one EXEC cycle into a one-hot ALU mode, operand
// selects and datapath write enables, and owns the PC.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem            fetch bus (master modport)
//   acc_zero_i      accumulator == 0
//   alu_c_i         ALU result, used as JMP/BEQZ target
//   alu_mode_o      one-hot ALU op (bits `ALU_MODE_*), only in EXEC
//   alu_a_sel_o     0 = acc, 1 = pc
//   alu_b_sel_o     0 = x[rd_idx], 1 = imm
//   imm_o, rd_idx_o insn[3:0], insn[2:0] (EXEC only)
//   reg_wr_en_o     write alu_c to x[rd_idx]
//   acc_wr_en_o     write alu_c to acc
//   pc_o            current PC
//   halted_o        core in HALT
//   illegal_o       sticky illegal-opcode flag
// Build option: define ILLEGAL_TRAP_EN to trap opcodes D/E into HALT and set
// illegal_o; otherwise they execute as NOP and illegal_o is tied low.

`ifndef ALU_MODE_COUNT
`define ALU_MODE_ADD      0
`define ALU_MODE_SHIFT    1
`define ALU_MODE_NOT      2
`define ALU_MODE_AND      3
`define ALU_MODE_OR       4
`define ALU_MODE_BYPASS_A 5
`define ALU_MODE_BYPASS_B 6
`define ALU_MODE_COUNT    7
`endif

module ctrl_unit #(
    parameter int                   BIT_COUNT = 8,
    parameter logic [BIT_COUNT-1:0] RESET_PC  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    ctrl_unit_if.master                imem,
    input  logic                       acc_zero_i,
    input  logic [BIT_COUNT-1:0]       alu_c_i,
    output logic [`ALU_MODE_COUNT-1:0] alu_mode_o,
    output logic                       alu_a_sel_o,
    output logic                       alu_b_sel_o,
    output logic [3:0]                 imm_o,
    output logic [2:0]                 rd_idx_o,
    output logic                       reg_wr_en_o,
    output logic                       acc_wr_en_o,
    output logic [BIT_COUNT-1:0]       pc_o,
    output logic                       halted_o,
    output logic                       illegal_o
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t               state_q;
    logic [BIT_COUNT-1:0] pc_q, pc_d;
    logic [7:0]           ir_q;
    logic                 halt_d;
`ifdef ILLEGAL_TRAP_EN
    logic                 illegal_q;
`endif

    // Outputs are gated by rst so they read as reset values in the same
    // cycle rst is raised, not only after the reset edge.
    assign pc_o           = rst ? RESET_PC : pc_q;
    assign imem.imem_addr = pc_o;
    assign imem.imem_req  = !rst && (state_q == S_FETCH);
    assign halted_o       = !rst && (state_q == S_HALT);
`ifdef ILLEGAL_TRAP_EN
    assign illegal_o      = !rst && illegal_q;
`else
    assign illegal_o      = 1'b0;
`endif

    // EXEC decode
    always_comb begin
        alu_mode_o  = '0;
        alu_a_sel_o = 1'b0;
        alu_b_sel_o = 1'b0;
        reg_wr_en_o = 1'b0;
        acc_wr_en_o = 1'b0;
        imm_o       = '0;
        rd_idx_o    = '0;
        if (!rst && state_q == S_EXEC) begin
            imm_o    = ir_q[3:0];
            rd_idx_o = ir_q[2:0];
            case (ir_q[7:4])
                4'h1: begin alu_mode_o[`ALU_MODE_ADD] = 1'b1; acc_wr_en_o = 1'b1; end
                4'h2: begin alu_mode_o[`ALU_MODE_ADD] = 1'b1; alu_b_sel_o = 1'b1; acc_wr_en_o = 1'b1; end
                4'h3: begin alu_mode_o[`ALU_MODE_SHIFT] = 1'b1; acc_wr_en_o = 1'b1; end
                4'h4: begin alu_mode_o[`ALU_MODE_SHIFT] = 1'b1; alu_b_sel_o = 1'b1; acc_wr_en_o = 1'b1; end
                4'h5: begin alu_mode_o[`ALU_MODE_NOT] = 1'b1; acc_wr_en_o = 1'b1; end
                4'h6: begin alu_mode_o[`ALU_MODE_AND] = 1'b1; acc_wr_en_o = 1'b1; end
                4'h7: begin alu_mode_o[`ALU_MODE_OR] = 1'b1; acc_wr_en_o = 1'b1; end
                4'h8: begin alu_mode_o[`ALU_MODE_BYPASS_A] = 1'b1; reg_wr_en_o = 1'b1; end
                4'h9: begin alu_mode_o[`ALU_MODE_BYPASS_B] = 1'b1; acc_wr_en_o = 1'b1; end
                4'hA: begin alu_mode_o[`ALU_MODE_BYPASS_B] = 1'b1; alu_b_sel_o = 1'b1; acc_wr_en_o = 1'b1; end
                4'hB: alu_mode_o[`ALU_MODE_BYPASS_A] = 1'b1;
                4'hC: begin alu_mode_o[`ALU_MODE_ADD] = 1'b1; alu_a_sel_o = 1'b1; alu_b_sel_o = 1'b1; end
                default: ;
            endcase
        end
    end

    // Next PC / halt decision at the end of EXEC
    always_comb begin
        pc_d   = pc_q + {{(BIT_COUNT-1){1'b0}}, 1'b1};
        halt_d = 1'b0;
        case (ir_q[7:4])
            4'hB: pc_d = alu_c_i;
            4'hC: if (acc_zero_i) pc_d = alu_c_i;
`ifdef ILLEGAL_TRAP_EN
            4'hD, 4'hE: begin pc_d = pc_q; halt_d = 1'b1; end
`endif
            4'hF: begin pc_d = pc_q; halt_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH: if (imem.imem_valid) begin
                    ir_q    <= imem.imem_rdata;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    pc_q    <= pc_d;
                    state_q <= halt_d ? S_HALT : S_FETCH;
`ifdef ILLEGAL_TRAP_EN
                    if (ir_q[7:4] == 4'hD || ir_q[7:4] == 4'hE) illegal_q <= 1'b1;
`endif
                end
                S_HALT: ;
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule
